// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller.
package serial_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; the only arithmetic element of the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    // Sum and carry of a single bit position
    assign s = a ^ b ^ cin;
    assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one result bit per clock, LSB first.
module serial_add_ctrl
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // One extra bit so the terminal count WIDTH-1 never wraps
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             sub_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             b_bit;
    logic             fa_s;
    logic             fa_c;

    // Subtraction is a + ~b + 1: invert B per bit, the +1 comes from the preloaded carry
    assign b_bit = b_sr[0] ^ sub_q;

    fa_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_bit),
        .cin (carry),
        .s   (fa_s),
        .c   (fa_c)
    );

    // FSM, shift registers, carry flop, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            sub_q  <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        sub_q <= sub;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    res_sr <= {fa_s, res_sr[WIDTH-1:1]};
                    carry  <= fa_c;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        // carry still holds the carry into the MSB here
                        sum   <= {fa_s, res_sr[WIDTH-1:1]};
                        cout  <= fa_c;
                        ovf   <= carry ^ fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
